// File: rtl/d_instr_queue_if.sv
// Handshake and field bundle between the fetch stage, the instruction queue and the
// decode stage.
//   slave  : the queue side. It takes flush, the F-side push channel, the D-side
//            ready and ext_op. It drives in_ready, the head entry and its split fields.
//   master : the environment side, which drives the queue.
// Parameters DEPTH and PC_W must match the d_instr_queue instance that uses this
// interface. The count width is derived from DEPTH.
interface d_instr_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [PC_W-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      ext_op;
  logic [PC_W-1:0] out_pc;
  logic [5:0]      Op;
  logic [4:0]      Rs;
  logic [4:0]      Rt;
  logic [4:0]      Rd;
  logic [4:0]      Shamt;
  logic [5:0]      func;
  logic [15:0]     Imm16;
  logic [25:0]     Addr26;
  logic [31:0]     Imm32;
  logic [CntW-1:0] count;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready, ext_op,
    input  in_ready, out_valid, out_pc, Op, Rs, Rt, Rd, Shamt, func, Imm16, Addr26,
           Imm32, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready, ext_op,
    output in_ready, out_valid, out_pc, Op, Rs, Rt, Rd, Shamt, func, Imm16, Addr26,
           Imm32, count
  );
endinterface

// File: rtl/d_instr_queue.sv
// F->D instruction buffer. It is a DEPTH-entry circular FIFO of {pc, instr} with a
// valid/ready handshake on both sides. An integrated field splitter drives the decode
// fields and the extended immediate from the head entry.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (pointers/count cleared, storage not reset)
//   bus      d_instr_queue_if.slave: flush, push channel (in_*), pop channel (out_*),
//            ext_op, split fields Op/Rs/Rt/Rd/Shamt/func/Imm16/Addr26/Imm32 and count
// Parameters: DEPTH (power of two, >= 2), PC_W.
// Optional feature, selected with the macro D_SPLIT_BYPASS_EN:
//   When the queue is empty, an incoming instruction is presented at the output in the
//   same cycle. If decode takes it, the instruction is never written.
module d_instr_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input logic              clk,
  input logic              reset_n,
  d_instr_queue_if.slave   bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            empty, full, bypass;
  logic            push, pop, wr_en, rd_en;
  logic [PC_W-1:0] head_pc;
  logic [31:0]     head_instr;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);

`ifdef D_SPLIT_BYPASS_EN
  assign bypass = empty & bus.in_valid & ~bus.flush;
`else
  assign bypass = 1'b0;
`endif

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty | bypass;
  assign bus.count     = count_q;

  // A flush cancels any handshake in the same cycle.
  assign push = bus.in_valid & ~full & ~bus.flush;
  assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

  // A bypassed word consumed in the same cycle never touches storage. A bypassed word
  // that is not consumed is written normally, and no stored entry is read.
  assign wr_en = push & ~(bypass & pop);
  assign rd_en = pop & ~bypass;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]    <= bus.in_pc;
      instr_mem[wr_ptr_q] <= bus.in_instr;
    end
  end

  // Head selection. All head-derived outputs are forced to zero when there is no
  // valid head.
  always_comb begin
    head_pc    = '0;
    head_instr = '0;
    if (bypass) begin
      head_pc    = bus.in_pc;
      head_instr = bus.in_instr;
    end else if (!empty) begin
      head_pc    = pc_mem[rd_ptr_q];
      head_instr = instr_mem[rd_ptr_q];
    end
  end

  assign bus.out_pc = head_pc;
  assign bus.Op     = head_instr[31:26];
  assign bus.Rs     = head_instr[25:21];
  assign bus.Rt     = head_instr[20:16];
  assign bus.Rd     = head_instr[15:11];
  assign bus.Shamt  = head_instr[10:6];
  assign bus.func   = head_instr[5:0];
  assign bus.Imm16  = head_instr[15:0];
  assign bus.Addr26 = head_instr[25:0];

  always_comb begin
    bus.Imm32 = '0;
    unique case (bus.ext_op)
      2'b00:   bus.Imm32 = {16'h0000, head_instr[15:0]};
      2'b01:   bus.Imm32 = {{16{head_instr[15]}}, head_instr[15:0]};
      2'b10:   bus.Imm32 = {head_instr[15:0], 16'h0000};
      default: bus.Imm32 = '0;
    endcase
  end
endmodule

// File: tb/tb_d_instr_queue.sv
// Randomised and directed bench for d_instr_queue. It compares the DUT against a
// queue-based reference model of the instruction buffer.
module tb_d_instr_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
`ifdef D_SPLIT_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  d_instr_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

  d_instr_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference model: the queue contents in order, each entry {pc, instr}.
  logic [PC_W+31:0] mq[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] imm_ext(input logic [1:0] eop, input logic [15:0] imm);
    int signed s;
    case (eop)
      2'd0:    return 32'(imm);
      2'd1:    begin s = int'($signed(imm)); return 32'(s); end
      2'd2:    return 32'(imm) * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic iv, input logic [PC_W-1:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl, input logic [1:0] eop);
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.ext_op    = eop;
  endtask

  // Compare every output with what the model says should be visible right now.
  task automatic expect_outputs();
    logic            ev;
    logic [PC_W-1:0] epc;
    logic [31:0]     ei;
    ev = 1'b0; epc = '0; ei = '0;
    if (mq.size() != 0) begin
      ev = 1'b1;
      {epc, ei} = mq[0];
    end else if (Byp && bus.in_valid && !bus.flush) begin
      ev = 1'b1; epc = bus.in_pc; ei = bus.in_instr;
    end
    check("out_valid", 64'(bus.out_valid), 64'(ev));
    check("in_ready", 64'(bus.in_ready), 64'(mq.size() != DEPTH));
    check("count", 64'(bus.count), 64'(mq.size()));
    check("out_pc", 64'(bus.out_pc), 64'(epc));
    check("op_rs_rt", 64'({bus.Op, bus.Rs, bus.Rt}), 64'(ei / 32'h10000));
    check("rd_sh_fn", 64'({bus.Rd, bus.Shamt, bus.func}), 64'(ei % 32'h10000));
    check("imm16", 64'(bus.Imm16), 64'(ei % 32'h10000));
    check("addr26", 64'(bus.Addr26), 64'(ei % 32'h4000000));
    check("imm32", 64'(bus.Imm32), 64'(imm_ext(bus.ext_op, 16'(ei % 32'h10000))));
  endtask

  // Advance one clock edge and apply the same handshake to the model.
  task automatic tick();
    bit fl, iv, ordy;
    int n;
    logic [PC_W+31:0] e;
    fl = bus.flush; iv = bus.in_valid; ordy = bus.out_ready; n = mq.size();
    e = {bus.in_pc, bus.in_instr};
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else if (!(Byp && n == 0 && iv && ordy)) begin
      if (n != 0 && ordy) void'(mq.pop_front());
      if (iv && n < DEPTH) mq.push_back(e);
    end
    #1;
  endtask

  task automatic cyc(input logic iv, input logic [PC_W-1:0] pc, input logic [31:0] ins,
                     input logic ordy, input logic fl, input logic [1:0] eop);
    drive(iv, pc, ins, ordy, fl, eop);
    #1;
    expect_outputs();
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] imm_tab [4];
    imm_tab[0] = 32'h0000_8001;
    imm_tab[1] = 32'hFFFF_8001;
    imm_tab[2] = 32'h8001_0000;
    imm_tab[3] = 32'h0000_0000;

    drive(1'b0, '0, '0, 1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push, visible at the head one cycle later.
    cyc(1'b1, 32'h3000, 32'h8C43_0004, 1'b0, 1'b0, 2'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 2'd0);
    #1;
    expect_outputs();
    check("lw_op", 64'(bus.Op), 64'h23);
    check("lw_rs", 64'(bus.Rs), 64'd2);
    check("lw_rt", 64'(bus.Rt), 64'd3);
    check("lw_imm", 64'(bus.Imm16), 64'h0004);
    check("lw_pc", 64'(bus.out_pc), 64'h3000);
    check("lw_count", 64'(bus.count), 64'd1);
    tick();

    // Fill past full with decode stalled, then drain in order.
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 2'd0);
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0, 2'd1);
    check("full_count", 64'(bus.count), 64'(DEPTH));
    check("full_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i <= DEPTH; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0, 2'd0);

    // Streaming push+pop: count constant while pointers wrap.
    cyc(1'b1, 32'h100, $urandom, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 32'h104, $urandom, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 3 * DEPTH; i++) cyc(1'b1, 32'(32'h200 + i * 4), $urandom, 1'b1, 1'b0, 2'd2);
    check("stream_count", 64'(bus.count), 64'd2);

    // Immediate extension on every ext_op.
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 2'd0);
    cyc(1'b1, 32'h40, 32'h0000_8001, 1'b0, 1'b0, 2'd0);
    for (int e = 0; e < 4; e++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 2'(e));
      #1;
      expect_outputs();
      check("imm32_tab", 64'(bus.Imm32), 64'(imm_tab[e]));
      tick();
    end

    // Flush with three entries and a concurrent push.
    cyc(1'b1, 32'h50, $urandom, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 32'h54, $urandom, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 32'h58, $urandom, 1'b1, 1'b1, 2'd0);
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_op", 64'(bus.Op), 64'd0);

    // Same-cycle bypass attempt on an empty queue.
    drive(1'b1, 32'h600, 32'h0085_1020, 1'b1, 1'b0, 2'd0);
    #1;
    expect_outputs();
    check("byp_valid", 64'(bus.out_valid), 64'(Byp));
    check("byp_func", 64'(bus.func), Byp ? 64'h20 : 64'h0);
    check("byp_rd", 64'(bus.Rd), Byp ? 64'd2 : 64'd0);
    tick();
    check("byp_count", 64'(bus.count), Byp ? 64'd0 : 64'd1);

    // Asynchronous reset in the middle of operation.
    cyc(1'b1, 32'h700, $urandom, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 32'h704, $urandom, 1'b0, 1'b0, 2'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 2'd0);
    reset_n = 1'b0;
    #1;
    check("async_count", 64'(bus.count), 64'd0);
    check("async_valid", 64'(bus.out_valid), 64'd0);
    mq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic with the fill/drain bias changing every block.
    for (int blk = 0; blk < 8; blk++) begin
      int pv, pr;
      pv = $urandom_range(1, 9);
      pr = $urandom_range(1, 9);
      for (int i = 0; i < 200; i++) begin
        cyc($urandom_range(0, 9) < pv, $urandom, $urandom, $urandom_range(0, 9) < pr,
            $urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
